// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control FSM:
//   - state_t     : FSM state encoding
//   - OP_*        : instruction opcodes (IR[31:26])
//   - SRCB_*      : alu_src_b mux encodings
//   - PCSRC_*     : pc_src mux encodings
//   - ALUOP_*     : ALU decoder control codes (zero-extended to ALUOP_W)
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPE_EX,
        S_ALU_WB,
        S_BRANCH,
        S_ADDI_EX,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

endpackage

// File: rtl/mips_next_state.sv
// -----------------------------------------------------------------------------
// mips_next_state
// Combinational next-state logic and illegal-opcode decode for the
// multi-cycle main control FSM.
// Ports:
//   state      in   current FSM state
//   op         in   IR opcode field, stable from DECODE until next FETCH
//   mem_ready  in   memory access complete (used only when MEM_HS=1)
//   next_state out  state to load on the next clock edge
//   illegal    out  opcode not supported (meaningful only in DECODE)
// -----------------------------------------------------------------------------
module mips_next_state
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HS = 1'b1,
    parameter bit EN_BNE = 1'b1
) (
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output state_t      next_state,
    output logic        illegal
);

    logic mem_done;

    // Without the handshake the memory always finishes in one cycle.
    assign mem_done = MEM_HS ? mem_ready : 1'b1;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state = state;
        illegal    = 1'b0;
        case (state)
            S_IDLE:     next_state = S_FETCH;
            S_FETCH:    if (mem_done) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     next_state = S_RTYPE_EX;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_BNE: begin
                        if (EN_BNE) begin
                            next_state = S_BRANCH;
                        end else begin
                            next_state = S_FETCH;
                            illegal    = 1'b1;
                        end
                    end
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach MEMADR, so a single compare picks the path.
            S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_done) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWR:    if (mem_done) next_state = S_FETCH;
            S_RTYPE_EX: next_state = S_ALU_WB;
            S_ADDI_EX:  next_state = S_ALU_WB;
            S_ALU_WB:   next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            default:    next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm
// Moore control FSM for a multi-cycle MIPS datapath. Sequences each
// instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath
// enables and mux selects.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   op         in   IR[31:26]
//   zero       in   ALU zero flag, valid in BRANCH
//   mem_ready  in   memory access complete this cycle
//   mem_req    out  memory request, held until ready
//   iord       out  0 = address from PC, 1 = from ALUOut
//   ir_write   out  load IR
//   mem_write  out  store strobe
//   reg_write  out  register file write
//   reg_dst    out  1 = rd, 0 = rt
//   memto_reg  out  1 = MDR, 0 = ALUOut
//   alu_src_a  out  0 = PC, 1 = A
//   alu_src_b  out  0 = B, 1 = 4, 2 = SignImm, 3 = SignImm<<2
//   alu_op     out  ALU decoder control (0 add, 1 sub, 2 funct)
//   pc_src     out  0 = ALU result, 1 = ALUOut, 2 = jump target
//   pc_en      out  PC load enable
//   illegal_op out  one-cycle pulse on an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_main_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 2,
    parameter bit          MEM_HS  = 1'b1,
    parameter bit          EN_BNE  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               memto_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               illegal_op
);

    state_t state;
    state_t next_state;
    logic   illegal;
    logic   fetch_done;
    logic   rtype_wb;   // 1 when ALU_WB was entered from RTYPE_EX

    assign fetch_done = MEM_HS ? mem_ready : 1'b1;

    mips_next_state #(
        .MEM_HS (MEM_HS),
        .EN_BNE (EN_BNE)
    ) u_next_state (
        .state      (state),
        .op         (op),
        .mem_ready  (mem_ready),
        .next_state (next_state),
        .illegal    (illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rtype_wb <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= next_state;
            if (state == S_RTYPE_EX) begin
                rtype_wb <= 1'b1;
            end else if (state == S_ADDI_EX) begin
                rtype_wb <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_W'(ALUOP_ADD);
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC update only on the cycle the fetch completes.
                ir_write  = fetch_done;
                pc_en     = fetch_done;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
            end
            S_MEMWR: begin
                // Strobe held through the wait; memory commits on mem_ready.
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALUOP_FUNCT);
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = rtype_wb;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALUOP_SUB);
                pc_src    = PCSRC_ALUOUT;
                pc_en     = (op == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
